// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared game-state encoding, width helpers and cell indexing for the bomb engine
package bomb_pkg;

  typedef enum logic [1:0] {
    GS_PLAY = 2'd0,
    GS_WIN  = 2'd1,
    GS_DRAW = 2'd2
  } game_state_e;

  // Bits needed to hold values 0..max_val (HP_W and FW both derive from this)
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx(input int x, input int y, input int grid_h);
    return x * grid_h + y;
  endfunction

endpackage

// File: rtl/blast_cross.sv
// rtl/blast_cross.sv - combinational blast cross of one detonating cell, clipped to the interior
module blast_cross
  import bomb_pkg::*;
#(
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 10,
  parameter int COORD_W = 4,
  parameter int RADIUS  = 2
) (
  input  logic [COORD_W-1:0]       i_cx,
  input  logic [COORD_W-1:0]       i_cy,
  input  logic                     i_detonate,
  output logic [GRID_W*GRID_H-1:0] o_mask
);

  int dx;
  int dy;

  // Distances are taken in signed int so a centre near 0 cannot wrap to the far edge
  always_comb begin
    o_mask = '0;
    dx     = 0;
    dy     = 0;
    for (int x = 1; x < GRID_W - 1; x++) begin
      for (int y = 1; y < GRID_H - 1; y++) begin
        dx = x - int'(i_cx);
        dy = y - int'(i_cy);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        if (i_detonate &&
            ((y == int'(i_cy) && dx <= RADIUS) ||
             (x == int'(i_cx) && dy <= RADIUS))) begin
          o_mask[idx(x, y, GRID_H)] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bomb_field.sv
// rtl/bomb_field.sv - fuse map, placement, tick-driven detonation, damage and game outcome
// Optional CHAIN_EXPLODE_EN: bombs inside a blast are forced to detonate on the next tick.
module bomb_field
  import bomb_pkg::*;
#(
  parameter int  GRID_W      = 10,
  parameter int  GRID_H      = 10,
  parameter int  COORD_W     = 4,
  parameter int  FUSE_TICKS  = 3,
  parameter int  RADIUS      = 2,
  parameter int  NUM_PLAYERS = 2,
  parameter int  HP_MAX      = 3,
  localparam int HP_W        = width_for(HP_MAX),
  localparam int FW          = width_for(FUSE_TICKS)
) (
  input  logic                            bombClk,
  input  logic                            rst,
  input  logic                            i_tick,
  input  logic                            i_place_valid,
  input  logic [COORD_W-1:0]              i_place_x,
  input  logic [COORD_W-1:0]              i_place_y,
  output logic                            o_place_ready,
  output logic                            o_place_err,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  i_player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  i_player_y,
  output logic [GRID_W*GRID_H*FW-1:0]     o_fuse_map,
  output logic [GRID_W*GRID_H-1:0]        o_blast_map,
  output logic [NUM_PLAYERS*HP_W-1:0]     o_health,
  output logic [NUM_PLAYERS-1:0]          o_alive,
  output logic [1:0]                      o_game_state,
  output logic [1:0]                      o_winner
);

  localparam int NCELL = GRID_W * GRID_H;

  logic [NCELL*FW-1:0]          fuse_q, fuse_d;
  logic [NCELL-1:0]             blast_q, blast_d;
  logic [NUM_PLAYERS*HP_W-1:0]  health_q, health_d;
  logic [NUM_PLAYERS-1:0]       alive_q, alive_d;
  game_state_e                  state_q, state_d;
  logic [1:0]                   winner_q, winner_d;
  logic                         err_q, err_d;

  logic                         playing;
  logic [NCELL-1:0]             detonate;
  logic [NCELL-1:0]             blast_union;
  logic [NCELL-1:0]             cross_mask [NCELL];

  assign playing = (state_q == GS_PLAY);

  always_comb begin
    detonate = '0;
    for (int c = 0; c < NCELL; c++) begin
      detonate[c] = playing && i_tick && (fuse_q[c*FW +: FW] == FW'(1));
    end
  end

  for (genvar gx = 0; gx < GRID_W; gx++) begin : g_col
    for (genvar gy = 0; gy < GRID_H; gy++) begin : g_row
      if (gx > 0 && gx < GRID_W - 1 && gy > 0 && gy < GRID_H - 1) begin : g_int
        blast_cross #(
          .GRID_W  (GRID_W),
          .GRID_H  (GRID_H),
          .COORD_W (COORD_W),
          .RADIUS  (RADIUS)
        ) u_cross (
          .i_cx       (COORD_W'(gx)),
          .i_cy       (COORD_W'(gy)),
          .i_detonate (detonate[gx*GRID_H + gy]),
          .o_mask     (cross_mask[gx*GRID_H + gy])
        );
      end else begin : g_border
        assign cross_mask[gx*GRID_H + gy] = '0;
      end
    end
  end

  always_comb begin
    blast_union = '0;
    for (int c = 0; c < NCELL; c++) begin
      blast_union = blast_union | cross_mask[c];
    end
  end

  logic [FW-1:0]   cur_fuse;
  logic [HP_W-1:0] cur_hp;
  int              place_x;
  int              place_y;
  int              place_cell;
  int              pl_x;
  int              pl_y;
  int              alive_cnt;
  int              last_alive;

  always_comb begin
    fuse_d     = fuse_q;
    blast_d    = blast_union;
    health_d   = health_q;
    alive_d    = alive_q;
    state_d    = state_q;
    winner_d   = winner_q;
    err_d      = 1'b0;
    cur_fuse   = '0;
    cur_hp     = '0;
    place_x    = int'(i_place_x);
    place_y    = int'(i_place_y);
    place_cell = 0;
    pl_x       = 0;
    pl_y       = 0;
    alive_cnt  = 0;
    last_alive = 0;

    if (playing) begin
      if (i_tick) begin
        for (int c = 0; c < NCELL; c++) begin
          cur_fuse = fuse_q[c*FW +: FW];
          if (cur_fuse > FW'(1)) begin
            fuse_d[c*FW +: FW] = cur_fuse - FW'(1);
`ifdef CHAIN_EXPLODE_EN
            if (blast_union[c]) fuse_d[c*FW +: FW] = FW'(1);
`endif
          end else if (cur_fuse == FW'(1)) begin
            fuse_d[c*FW +: FW] = '0;
          end
        end
      end

      // Placement sees the post-tick map, so a cell detonating now can be re-armed
      if (i_place_valid) begin
        if (place_x >= 1 && place_x <= GRID_W - 2 &&
            place_y >= 1 && place_y <= GRID_H - 2) begin
          place_cell = idx(place_x, place_y, GRID_H);
          if (fuse_d[place_cell*FW +: FW] == '0) begin
            fuse_d[place_cell*FW +: FW] = FW'(FUSE_TICKS);
`ifdef CHAIN_EXPLODE_EN
            if (blast_union[place_cell]) fuse_d[place_cell*FW +: FW] = FW'(1);
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end

      for (int p = 0; p < NUM_PLAYERS; p++) begin
        pl_x   = int'(i_player_x[p*COORD_W +: COORD_W]);
        pl_y   = int'(i_player_y[p*COORD_W +: COORD_W]);
        cur_hp = health_q[p*HP_W +: HP_W];
        if (pl_x < GRID_W && pl_y < GRID_H) begin
          if (blast_union[idx(pl_x, pl_y, GRID_H)] && cur_hp != '0) begin
            health_d[p*HP_W +: HP_W] = cur_hp - HP_W'(1);
          end
        end
      end

      for (int p = 0; p < NUM_PLAYERS; p++) begin
        alive_d[p] = (health_d[p*HP_W +: HP_W] != '0);
        if (alive_d[p]) begin
          alive_cnt  = alive_cnt + 1;
          last_alive = p;
        end
      end

      if (alive_cnt >= 2) begin
        state_d = GS_PLAY;
      end else if (alive_cnt == 1) begin
        state_d  = GS_WIN;
        winner_d = 2'(last_alive);
      end else begin
        state_d = GS_DRAW;
      end
    end
  end

  always_ff @(posedge bombClk or posedge rst) begin
    if (rst) begin
      fuse_q   <= '0;
      blast_q  <= '0;
      health_q <= {NUM_PLAYERS{HP_W'(HP_MAX)}};
      alive_q  <= '1;
      state_q  <= GS_PLAY;
      winner_q <= '0;
      err_q    <= 1'b0;
    end else begin
      fuse_q   <= fuse_d;
      blast_q  <= blast_d;
      health_q <= health_d;
      alive_q  <= alive_d;
      state_q  <= state_d;
      winner_q <= winner_d;
      err_q    <= err_d;
    end
  end

  assign o_place_ready = playing;
  assign o_place_err   = err_q;
  assign o_fuse_map    = fuse_q;
  assign o_blast_map   = blast_q;
  assign o_health      = health_q;
  assign o_alive       = alive_q;
  assign o_game_state  = state_q;
  assign o_winner      = winner_q;

endmodule

// File: tb/tb_bomb_field.sv
// tb/tb_bomb_field.sv - directed and randomized checks of bomb_field against a cell-array reference model
module tb_bomb_field;

  localparam int GW  = 10;
  localparam int GH  = 10;
  localparam int CW  = 4;
  localparam int FT  = 3;
  localparam int R   = 2;
  localparam int NP  = 2;
  localparam int HPM = 3;
  localparam int HPW = 2;
  localparam int FW  = 2;

  logic                  bombClk = 1'b0;
  logic                  rst = 1'b1;
  logic                  i_tick = 1'b0;
  logic                  i_place_valid = 1'b0;
  logic [CW-1:0]         i_place_x = '0;
  logic [CW-1:0]         i_place_y = '0;
  logic                  o_place_ready;
  logic                  o_place_err;
  logic [NP*CW-1:0]      i_player_x = '0;
  logic [NP*CW-1:0]      i_player_y = '0;
  logic [GW*GH*FW-1:0]   o_fuse_map;
  logic [GW*GH-1:0]      o_blast_map;
  logic [NP*HPW-1:0]     o_health;
  logic [NP-1:0]         o_alive;
  logic [1:0]            o_game_state;
  logic [1:0]            o_winner;

  bomb_field dut (
    .bombClk       (bombClk),
    .rst           (rst),
    .i_tick        (i_tick),
    .i_place_valid (i_place_valid),
    .i_place_x     (i_place_x),
    .i_place_y     (i_place_y),
    .o_place_ready (o_place_ready),
    .o_place_err   (o_place_err),
    .i_player_x    (i_player_x),
    .i_player_y    (i_player_y),
    .o_fuse_map    (o_fuse_map),
    .o_blast_map   (o_blast_map),
    .o_health      (o_health),
    .o_alive       (o_alive),
    .o_game_state  (o_game_state),
    .o_winner      (o_winner)
  );

  always #5 bombClk = ~bombClk;

  int n_checks = 0;
  int n_errors = 0;

  int m_fuse [GW][GH];
  bit m_blast [GW][GH];
  int m_hp [NP];
  int m_state;
  int m_winner;
  bit m_err;
  int m_px [NP];
  int m_py [NP];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit interior(input int x, input int y);
    return x >= 1 && x <= GW - 2 && y >= 1 && y <= GH - 2;
  endfunction

  task automatic model_reset();
    foreach (m_fuse[i, j]) begin
      m_fuse[i][j]  = 0;
      m_blast[i][j] = 0;
    end
    foreach (m_hp[p]) m_hp[p] = HPM;
    m_state  = 0;
    m_winner = 0;
    m_err    = 0;
  endtask

  task automatic model_step(input bit tick, input bit pv, input int x, input int y);
    bit bl [GW][GH];
    int alive;
    int last;
    foreach (bl[i, j]) bl[i][j] = 0;
    m_err = 0;
    alive = 0;
    last  = 0;
    if (m_state == 0) begin
      if (tick) begin
        for (int bx = 0; bx < GW; bx++)
          for (int by = 0; by < GH; by++)
            if (m_fuse[bx][by] == 1)
              for (int d = -R; d <= R; d++) begin
                if (interior(bx + d, by)) bl[bx + d][by] = 1;
                if (interior(bx, by + d)) bl[bx][by + d] = 1;
              end
        foreach (m_fuse[i, j]) begin
          if (m_fuse[i][j] > 1) begin
            m_fuse[i][j]--;
`ifdef CHAIN_EXPLODE_EN
            if (bl[i][j]) m_fuse[i][j] = 1;
`endif
          end else if (m_fuse[i][j] == 1) begin
            m_fuse[i][j] = 0;
          end
        end
        for (int p = 0; p < NP; p++)
          if (bl[m_px[p]][m_py[p]] && m_hp[p] > 0) m_hp[p]--;
      end
      if (pv) begin
        if (interior(x, y) && m_fuse[x][y] == 0) begin
          m_fuse[x][y] = FT;
`ifdef CHAIN_EXPLODE_EN
          if (bl[x][y]) m_fuse[x][y] = 1;
`endif
        end else begin
          m_err = 1;
        end
      end
      for (int p = 0; p < NP; p++)
        if (m_hp[p] > 0) begin
          alive++;
          last = p;
        end
      if (alive == 1) begin
        m_state  = 1;
        m_winner = last;
      end else if (alive == 0) begin
        m_state = 2;
      end
    end
    m_blast = bl;
  endtask

  task automatic compare_all(input string tag);
    logic [255:0] ef;
    logic [255:0] eb;
    logic [255:0] eh;
    logic [255:0] ea;
    ef = '0;
    eb = '0;
    eh = '0;
    ea = '0;
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++) begin
        ef[(x*GH + y)*FW +: FW] = FW'(m_fuse[x][y]);
        eb[x*GH + y]            = m_blast[x][y];
      end
    for (int p = 0; p < NP; p++) begin
      eh[p*HPW +: HPW] = HPW'(m_hp[p]);
      ea[p]            = (m_hp[p] != 0);
    end
    check_eq({tag, ".fuse"},   256'(o_fuse_map),    ef);
    check_eq({tag, ".blast"},  256'(o_blast_map),   eb);
    check_eq({tag, ".health"}, 256'(o_health),      eh);
    check_eq({tag, ".alive"},  256'(o_alive),       ea);
    check_eq({tag, ".state"},  256'(o_game_state),  256'(m_state));
    check_eq({tag, ".winner"}, 256'(o_winner),      256'(m_winner));
    check_eq({tag, ".err"},    256'(o_place_err),   256'(m_err));
    check_eq({tag, ".ready"},  256'(o_place_ready), 256'(m_state == 0));
  endtask

  task automatic set_players(input int x0, input int y0, input int x1, input int y1);
    m_px[0] = x0;
    m_py[0] = y0;
    m_px[1] = x1;
    m_py[1] = y1;
    for (int p = 0; p < NP; p++) begin
      i_player_x[p*CW +: CW] = CW'(m_px[p]);
      i_player_y[p*CW +: CW] = CW'(m_py[p]);
    end
  endtask

  task automatic step(input string tag, input bit tick, input bit pv, input int x, input int y);
    i_tick        = tick;
    i_place_valid = pv;
    i_place_x     = CW'(x);
    i_place_y     = CW'(y);
    model_step(tick, pv, x, y);
    @(posedge bombClk);
    #1;
    compare_all(tag);
    i_tick        = 1'b0;
    i_place_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge bombClk);
    #1;
    model_reset();
    compare_all(tag);
    rst = 1'b0;
  endtask

  function automatic int fuse_at(input int x, input int y);
    logic [GW*GH*FW-1:0] v;
    v = o_fuse_map;
    return int'(v[(x*GH + y)*FW +: FW]);
  endfunction

  function automatic int hp_at(input int p);
    logic [NP*HPW-1:0] v;
    v = o_health;
    return int'(v[p*HPW +: HPW]);
  endfunction

  logic [GW*GH-1:0] cross33;

  initial begin
    set_players(8, 8, 8, 7);
    model_reset();
    #1;
    do_reset("reset");

    // Single bomb countdown, rejects, and the expected cross
    step("place33", 0, 1, 3, 3);
    check_eq("place33_fuse", 256'(fuse_at(3, 3)), 256'(3));
    step("dup33", 0, 1, 3, 3);
    check_eq("dup33_err", 256'(o_place_err), 256'(1));
    step("border04", 0, 1, 0, 4);
    check_eq("border04_err", 256'(o_place_err), 256'(1));
    step("tick1", 1, 0, 0, 0);
    check_eq("tick1_fuse", 256'(fuse_at(3, 3)), 256'(2));
    step("tick2", 1, 0, 0, 0);
    check_eq("tick2_fuse", 256'(fuse_at(3, 3)), 256'(1));
    step("tick3", 1, 0, 0, 0);
    cross33 = '0;
    for (int k = 1; k <= 5; k++) begin
      cross33[k*GH + 3] = 1'b1;
      cross33[3*GH + k] = 1'b1;
    end
    check_eq("tick3_cross", 256'(o_blast_map), 256'(cross33));
    step("blast_clear", 0, 0, 0, 0);
    check_eq("blast_clear_map", 256'(o_blast_map), 256'(0));

    // Edge of grid: no wraparound hit
    set_players(1, 1, 8, 1);
    do_reset("reset_edge");
    step("place21", 0, 1, 2, 1);
    for (int t = 0; t < 3; t++) step("edge_tick", 1, 0, 0, 0);
    check_eq("edge_hp0", 256'(hp_at(0)), 256'(2));
    check_eq("edge_hp1", 256'(hp_at(1)), 256'(3));

    // Re-arming a cell on the tick that detonates it
    set_players(8, 8, 8, 7);
    do_reset("reset_rearm");
    step("place55", 0, 1, 5, 5);
    step("rearm_t1", 1, 0, 0, 0);
    step("rearm_t2", 1, 0, 0, 0);
    step("rearm_t3", 1, 1, 5, 5);
`ifdef CHAIN_EXPLODE_EN
    check_eq("rearm_fuse", 256'(fuse_at(5, 5)), 256'(1));
`else
    check_eq("rearm_fuse", 256'(fuse_at(5, 5)), 256'(FT));
`endif
    check_eq("rearm_err", 256'(o_place_err), 256'(0));
    check_eq("rearm_blast", 256'(o_blast_map[5*GH + 5]), 256'(1));
    rst = 1'b1;
    #2;
    check_eq("async_rst_blast", 256'(o_blast_map), 256'(0));
    check_eq("async_rst_fuse", 256'(o_fuse_map), 256'(0));
    @(posedge bombClk);
    #1;
    model_reset();
    rst = 1'b0;

    // Two crosses per round, both players on one cell, ending in a draw
    set_players(3, 3, 3, 3);
    do_reset("reset_draw");
    for (int r = 0; r < HPM; r++) begin
      step("draw_p1", 0, 1, 3, 4);
      step("draw_p2", 0, 1, 2, 3);
      for (int t = 0; t < FT; t++) step("draw_tick", 1, 0, 0, 0);
      if (r == 0) check_eq("double_hit_hp1", 256'(hp_at(1)), 256'(2));
    end
    check_eq("draw_state", 256'(o_game_state), 256'(2));
    step("draw_frozen", 1, 1, 5, 5);
    check_eq("draw_frozen_fuse", 256'(fuse_at(5, 5)), 256'(0));
    check_eq("draw_frozen_ready", 256'(o_place_ready), 256'(0));

`ifdef CHAIN_EXPLODE_EN
    set_players(8, 8, 8, 7);
    do_reset("reset_chain");
    step("chain_p33", 0, 1, 3, 3);
    step("chain_t1", 1, 0, 0, 0);
    step("chain_t2", 1, 0, 0, 0);
    step("chain_p35", 0, 1, 3, 5);
    step("chain_t3", 1, 0, 0, 0);
    check_eq("chain_fuse35", 256'(fuse_at(3, 5)), 256'(1));
    step("chain_t4", 1, 0, 0, 0);
    check_eq("chain_fuse35_done", 256'(fuse_at(3, 5)), 256'(0));
`endif

    // Randomized games with moving players
    for (int g = 0; g < 6; g++) begin
      set_players($urandom_range(0, GW - 1), $urandom_range(0, GH - 1),
                  $urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
      do_reset("rand_reset");
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 7) == 0)
          set_players($urandom_range(0, GW - 1), $urandom_range(0, GH - 1),
                      $urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
        step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
